if1_pc_gen: RTL and testbench
=============================

# if1_pc_gen

Program-counter generator and branch predictor for the IF1 stage. It holds the fetch PC and picks the next PC each cycle: reset vector, redirect from hazard control, hold on stall, or a BTB/2-bit-counter prediction. It drives the IF1 PC and the prediction bit that travels with the instruction. EX-stage branch resolution trains the predictor.

## Interface
- `RESET_PC`, default 32'h1c000000: fetch address loaded by reset.
- `BTB_IDX_W`, default 4: index width; the table holds 2^BTB_IDX_W entries, direct-mapped.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `pc_wen` input 1: 1 = advance the PC; 0 = hold (stall).
- `pc_is_wrong` input 1: redirect request from hazard control.
- `pc_correct` input 32: redirect target.
- `upd_valid` input 1: EX resolution is valid this cycle.
- `upd_pc` input 32: PC of the resolved instruction.
- `upd_is_branch` input 1: the resolved instruction is a branch or jump.
- `upd_taken` input 1: resolved direction.
- `upd_target` input 32: resolved target address.
- `if1_pc` output 32: current fetch PC (registered).
- `if1_valid` output 1: the fetch PC is meaningful.
- `if1_branch_bp` output 1: `if1_pc` is predicted taken.
- `if1_bp_target` output 32: predicted target; 0 when `if1_branch_bp`=0.

## Operation
- **BTB entry fields:** `valid`, `tag` = pc[31:BTB_IDX_W+2], `target`[31:0], `ctr`[1:0].
- **Entry addressing:** index = pc[BTB_IDX_W+1:2].
- **Lookup:** combinational on `if1_pc`.
  - hit = `valid` && tag match.
  - `if1_branch_bp` = hit && `ctr`[1].
  - `if1_bp_target` = `target` when `if1_branch_bp`=1, otherwise 0.
- **Next PC, in priority order:**
  1. `rst` → `RESET_PC`.
  2. `pc_is_wrong` → `pc_correct`. This applies even when `pc_wen`=0.
  3. `pc_wen`=0 → hold `if1_pc`.
  4. `if1_branch_bp` → `if1_bp_target`.
  5. Otherwise → `if1_pc` + 4, modulo 2^32. 32'hfffffffc wraps to 0.
- **`if1_valid`:**
  - 0 in the cycle after `rst`.
  - 1 from the next edge on.
  - Cleared only by reset.
- **Training (`upd_valid`=1), at the indexed entry of `upd_pc`:**
  - Branch, hit: saturating `ctr` update (taken → +1 up to 11; not taken → −1 down to 00). If taken, `target` ← `upd_target`.
  - Branch, miss, taken: allocate. `valid`=1, tag and `target` written, `ctr`=2'b10. Any previous entry at that index is replaced.
  - Branch, miss, not taken: no write.
  - Not a branch, hit (stale or aliased prediction): `valid` ← 0.
  - Not a branch, miss: no write.
- **Reset:** clears every `valid` bit. `target` and `ctr` are don't-care while invalid.

## Timing
- **Reset values:**
  - `if1_pc` = `RESET_PC`.
  - `if1_valid` = 0.
  - `if1_branch_bp` = 0 (table empty).
  - `if1_bp_target` = 0.
- **Latency:**
  - Redirect and stall take effect on the next edge: `pc_is_wrong` sampled at edge N gives `if1_pc` = `pc_correct` after edge N.
  - A prediction is applied in the same cycle it is looked up; there is no bubble.
- **Update visibility:** a table write at edge N is seen by lookups from cycle N+1. A same-cycle lookup of the same index sees the old contents; there is no bypass.
- **Simultaneous events:**
  - Update and redirect in the same cycle: both take effect.
  - `rst` and `upd_valid` together: reset wins and no entry is written.
- **Reset asserted mid-stream:** discards any pending redirect or stall. The PC returns to `RESET_PC` on that edge.

## Configuration
- **`IF1_BTB_EN` defined:** the BTB and 2-bit counters are built as described above.
- **`IF1_BTB_EN` undefined:**
  - No table storage is built.
  - `if1_branch_bp` = 0 and `if1_bp_target` = 0 constantly.
  - Next PC is `pc_correct`, hold, or `if1_pc` + 4 only.
  - All `upd_*` inputs are ignored.

## Test plan
- **Reset sequence:** `rst` high 2 cycles, then low with `pc_wen`=1 → `if1_pc` = 1c000000, then 1c000004, then 1c000008. `if1_valid` goes 0 → 1 one edge after reset drops.
- **Stall and redirect:**
  - `pc_wen`=0 for 3 cycles at 1c000010 → PC held at 1c000010.
  - Then `pc_is_wrong`=1 with `pc_correct`=1c000100 while `pc_wen`=0 → next `if1_pc` = 1c000100.
- **Allocate and predict:**
  - Update with pc=1c000020, branch, taken, target=1c000080.
  - Later fetch at 1c000020 → `if1_branch_bp`=1, `if1_bp_target`=1c000080, next `if1_pc`=1c000080.
- **Counter training:**
  - Two not-taken updates on 1c000020 move `ctr` 10 → 01 → 00, so the next fetch predicts not taken and goes to 1c000024.
  - Three taken updates saturate `ctr` at 11.
- **Alias invalidation:**
  - With 16 entries, an update at pc=1c000060 (same index as 1c000020, different tag), branch, taken, target=1c000200 replaces the entry.
  - A non-branch update at 1c000060 then clears `valid`; a fetch at 1c000060 then predicts not taken.
- **Wrap and macro-off build:**
  - `if1_pc`=fffffffc with `pc_wen`=1 → next `if1_pc`=00000000.
  - With `IF1_BTB_EN` undefined, repeat the allocate-and-predict scenario → `if1_branch_bp` stays 0.

Source files
------------

// File: rtl/if1_pc_gen.sv
// IF1 program-counter generator with optional direct-mapped BTB + 2-bit counters.
// Define IF1_BTB_EN to build the predictor; otherwise the PC only steps, holds or redirects.
module if1_pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_wen,
  input  logic        pc_is_wrong,
  input  logic [31:0] pc_correct,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_branch,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] if1_pc,
  output logic        if1_valid,
  output logic        if1_branch_bp,
  output logic [31:0] if1_bp_target
);

  logic [31:0] pc_nxt;

`ifdef IF1_BTB_EN
  localparam int DEPTH = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t btb [DEPTH];

  // Lookup on the live fetch PC
  logic [BTB_IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  btb_entry_t           lk_ent;
  logic                 lk_hit;

  assign lk_idx        = if1_pc[BTB_IDX_W+1:2];
  assign lk_tag        = if1_pc[31:BTB_IDX_W+2];
  assign lk_ent        = btb[lk_idx];
  assign lk_hit        = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign if1_branch_bp = lk_hit && lk_ent.ctr[1];
  assign if1_bp_target = if1_branch_bp ? lk_ent.target : 32'h0;

  // Training from EX resolution
  logic [BTB_IDX_W-1:0] up_idx;
  logic [TAG_W-1:0]     up_tag;
  btb_entry_t           up_ent;
  logic                 up_hit;
  logic [1:0]           ctr_nxt;
  logic [1:0]           unused_upd_lsb;

  assign up_idx         = upd_pc[BTB_IDX_W+1:2];
  assign up_tag         = upd_pc[31:BTB_IDX_W+2];
  assign up_ent         = btb[up_idx];
  assign up_hit         = up_ent.valid && (up_ent.tag == up_tag);
  assign unused_upd_lsb = upd_pc[1:0];

  always_comb begin
    ctr_nxt = up_ent.ctr;
    if (upd_taken) begin
      if (up_ent.ctr != 2'b11) ctr_nxt = up_ent.ctr + 2'b01;
    end else begin
      if (up_ent.ctr != 2'b00) ctr_nxt = up_ent.ctr - 2'b01;
    end
  end

  // Only valid bits are reset; target/ctr are ignored while invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) btb[i].valid <= 1'b0;
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        if (up_hit) begin
          btb[up_idx].ctr <= ctr_nxt;
          if (upd_taken) btb[up_idx].target <= upd_target;
        end else if (upd_taken) begin
          btb[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: 2'b10};
        end
      end else if (up_hit) begin
        btb[up_idx].valid <= 1'b0;
      end
    end
  end
`else
  logic unused_upd;

  assign if1_branch_bp = 1'b0;
  assign if1_bp_target = 32'h0;
  assign unused_upd    = ^{upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target};
`endif

  // Redirect beats stall; prediction only matters when advancing
  always_comb begin
    pc_nxt = if1_pc + 32'd4;
    if (pc_is_wrong)        pc_nxt = pc_correct;
    else if (!pc_wen)       pc_nxt = if1_pc;
    else if (if1_branch_bp) pc_nxt = if1_bp_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if1_pc    <= RESET_PC;
      if1_valid <= 1'b0;
    end else begin
      if1_pc    <= pc_nxt;
      if1_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if1_pc_gen.sv
// Directed + random bench for if1_pc_gen against an associative-array predictor model.
module tb_if1_pc_gen;
  localparam int          IW    = 4;
  localparam logic [31:0] RSTPC = 32'h1c000000;
`ifdef IF1_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_wen = 1'b0;
  logic        pc_is_wrong = 1'b0;
  logic [31:0] pc_correct = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_branch = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [31:0] if1_pc;
  logic        if1_valid;
  logic        if1_branch_bp;
  logic [31:0] if1_bp_target;

  if1_pc_gen #(.RESET_PC(RSTPC), .BTB_IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .pc_wen(pc_wen), .pc_is_wrong(pc_is_wrong),
    .pc_correct(pc_correct), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_is_branch(upd_is_branch), .upd_taken(upd_taken), .upd_target(upd_target),
    .if1_pc(if1_pc), .if1_valid(if1_valid), .if1_branch_bp(if1_branch_bp),
    .if1_bp_target(if1_bp_target)
  );

  always #5 clk = ~clk;

  // Model: table slot exists only while valid; stores the full branch PC
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  ent_t        tbl [int];
  logic [31:0] m_pc  = '0;
  logic        m_vld = 1'b0;
  int          vectors = 0;
  int          fails   = 0;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % (1 << IW));
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int s = slot(pc);
    return BTB_ON && tbl.exists(s) && ((tbl[s].pc >> (IW + 2)) == (pc >> (IW + 2)));
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit bp, output logic [31:0] bt);
    bp = 1'b0;
    bt = '0;
    if (m_hit(pc) && tbl[slot(pc)].ctr >= 2) begin
      bp = 1'b1;
      bt = tbl[slot(pc)].tgt;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit wen, input bit wr, input logic [31:0] corr,
                      input bit uv, input logic [31:0] upc, input bit ub, input bit ut,
                      input logic [31:0] utgt);
    bit          bp;
    logic [31:0] bt, npc;
    int          s;
    rst = r; pc_wen = wen; pc_is_wrong = wr; pc_correct = corr;
    upd_valid = uv; upd_pc = upc; upd_is_branch = ub; upd_taken = ut; upd_target = utgt;
    m_lookup(m_pc, bp, bt);
    if (r)        npc = RSTPC;
    else if (wr)  npc = corr;
    else if (!wen) npc = m_pc;
    else if (bp)  npc = bt;
    else          npc = m_pc + 32'd4;
    @(posedge clk);
    if (r) begin
      tbl.delete();
      m_vld = 1'b0;
    end else begin
      m_vld = 1'b1;
      s = slot(upc);
      if (BTB_ON && uv) begin
        if (ub) begin
          if (m_hit(upc)) begin
            if (ut) begin
              tbl[s].ctr = (tbl[s].ctr == 3) ? 3 : tbl[s].ctr + 1;
              tbl[s].tgt = utgt;
            end else begin
              tbl[s].ctr = (tbl[s].ctr == 0) ? 0 : tbl[s].ctr - 1;
            end
          end else if (ut) begin
            tbl[s] = '{pc: upc, tgt: utgt, ctr: 2};
          end
        end else if (m_hit(upc)) begin
          tbl.delete(s);
        end
      end
    end
    m_pc = npc;
    #1;
    m_lookup(m_pc, bp, bt);
    chk("pc", if1_pc, m_pc);
    chk("valid", {31'b0, if1_valid}, {31'b0, m_vld});
    chk("bp", {31'b0, if1_branch_bp}, {31'b0, bp});
    chk("bp_target", if1_bp_target, bt);
  endtask

  task automatic run(input bit wen);
    step(1'b0, wen, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask
  task automatic redir(input logic [31:0] a);
    step(1'b0, 1'b0, 1'b1, a, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask
  task automatic upd(input logic [31:0] pc, input bit br, input bit tk, input logic [31:0] tg);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, pc, br, tk, tg);
  endtask

  logic [31:0] addr_pool [8] = '{32'h1c000020, 32'h1c000060, 32'h1c000024, 32'h1c000080,
                                 32'h1c000100, 32'h1c000040, 32'h1c0000a0, 32'hfffffffc};

  initial begin
    // Reset sequence
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("rst_pc", if1_pc, 32'h1c000000);
    chk("rst_valid", {31'b0, if1_valid}, 32'h0);
    chk("rst_bp", {31'b0, if1_branch_bp}, 32'h0);
    run(1'b1);
    chk("seq_pc4", if1_pc, 32'h1c000004);
    chk("valid_up", {31'b0, if1_valid}, 32'h1);
    run(1'b1); run(1'b1); run(1'b1);
    // Stall then redirect while stalled
    run(1'b0); run(1'b0); run(1'b0);
    chk("stall_pc", if1_pc, 32'h1c000010);
    redir(32'h1c000100);
    chk("redir_pc", if1_pc, 32'h1c000100);
    // Allocate and predict
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h1c000020, 1'b1, 1'b1, 32'h1c000080);
    redir(32'h1c000020);
    chk("alloc_bp", {31'b0, if1_branch_bp}, {31'b0, BTB_ON});
    run(1'b1);
    chk("pred_pc", if1_pc, BTB_ON ? 32'h1c000080 : 32'h1c000024);
    // Counter down-training then saturation
    upd(32'h1c000020, 1'b1, 1'b0, '0);
    upd(32'h1c000020, 1'b1, 1'b0, '0);
    redir(32'h1c000020);
    run(1'b1);
    chk("nt_pc", if1_pc, 32'h1c000024);
    upd(32'h1c000020, 1'b1, 1'b1, 32'h1c000080);
    upd(32'h1c000020, 1'b1, 1'b1, 32'h1c000080);
    upd(32'h1c000020, 1'b1, 1'b1, 32'h1c000080);
    upd(32'h1c000020, 1'b1, 1'b0, '0);
    redir(32'h1c000020);
    run(1'b1);
    // Alias replace then non-branch invalidation
    upd(32'h1c000060, 1'b1, 1'b1, 32'h1c000200);
    redir(32'h1c000020);
    redir(32'h1c000060);
    chk("alias_tgt", if1_bp_target, BTB_ON ? 32'h1c000200 : 32'h0);
    upd(32'h1c000060, 1'b0, 1'b0, '0);
    redir(32'h1c000060);
    chk("inval_bp", {31'b0, if1_branch_bp}, 32'h0);
    // Reset beats a simultaneous update
    step(1'b1, 1'b1, 1'b1, 32'h1c000500, 1'b1, 32'h1c000040, 1'b1, 1'b1, 32'h1c000300);
    chk("rst_mid_pc", if1_pc, 32'h1c000000);
    redir(32'h1c000040);
    chk("rst_noalloc", {31'b0, if1_branch_bp}, 32'h0);
    // Wrap
    redir(32'hfffffffc);
    run(1'b1);
    chk("wrap_pc", if1_pc, 32'h0);
    // Random traffic over a small address pool so hits and aliases are frequent
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(5) == 0,
           addr_pool[$urandom_range(6)], $urandom_range(1) == 1, addr_pool[$urandom_range(7)],
           $urandom_range(3) != 0, $urandom_range(2) != 0, addr_pool[$urandom_range(6)]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
